// File: rtl/datapath_if.sv
// Instruction/control bundle and observation outputs of the 4x8 register-file datapath.
interface datapath_if;
  logic       reg_write_enable_ctrl;
  logic [1:0] alu_op_select_ctrl;
  logic       alu_operand_b_select_ctrl;
  logic [1:0] rx_addr_instr;
  logic [1:0] ry_addr_instr;
  logic [7:0] immediate_instr;
  logic [1:0] display_reg_select;
  logic [7:0] hex_display_data;
  logic [7:0] r0_debug;
  logic [7:0] r1_debug;
  logic [7:0] r2_debug;
  logic [7:0] r3_debug;

  modport master (
    output reg_write_enable_ctrl, alu_op_select_ctrl, alu_operand_b_select_ctrl,
           rx_addr_instr, ry_addr_instr, immediate_instr, display_reg_select,
    input  hex_display_data, r0_debug, r1_debug, r2_debug, r3_debug
  );

  modport slave (
    input  reg_write_enable_ctrl, alu_op_select_ctrl, alu_operand_b_select_ctrl,
           rx_addr_instr, ry_addr_instr, immediate_instr, display_reg_select,
    output hex_display_data, r0_debug, r1_debug, r2_debug, r3_debug
  );
endinterface

// File: rtl/datapath.sv
// Four 8-bit registers feeding a combinational 2-operand ALU; result written back to Rx.
module datapath (
  input  logic     clk,
  input  logic     rst_n,
  datapath_if.slave bus
);

  typedef enum logic [1:0] {
    ALU_PASS_B = 2'b00,
    ALU_ADD    = 2'b01,
    ALU_XOR    = 2'b10,
    ALU_PASS_A = 2'b11
  } alu_op_e;

  logic [3:0][7:0] regs;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [7:0]      alu_result;

  // Reads are combinational, so operands always see pre-edge contents (Rx==Ry included).
  always_comb begin
    op_a = regs[bus.rx_addr_instr];
    op_b = bus.alu_operand_b_select_ctrl ? bus.immediate_instr : regs[bus.ry_addr_instr];
  end

  always_comb begin
    alu_result = op_b;
    case (alu_op_e'(bus.alu_op_select_ctrl))
      ALU_PASS_B: alu_result = op_b;
      ALU_ADD:    alu_result = op_a + op_b;
      ALU_XOR:    alu_result = op_a ^ op_b;
      ALU_PASS_A: alu_result = op_a;
      default:    alu_result = op_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (bus.reg_write_enable_ctrl) begin
      regs[bus.rx_addr_instr] <= alu_result;
    end
  end

  assign bus.hex_display_data = regs[bus.display_reg_select];
  assign bus.r0_debug         = regs[0];
  assign bus.r1_debug         = regs[1];
  assign bus.r2_debug         = regs[2];
  assign bus.r3_debug         = regs[3];

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed program sequences plus randomized ops vs. a reference model.
module tb_datapath;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [7:0] model [4];

  datapath_if dp_if ();

  datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " r0"}, dp_if.r0_debug, model[0]);
    check({tag, " r1"}, dp_if.r1_debug, model[1]);
    check({tag, " r2"}, dp_if.r2_debug, model[2]);
    check({tag, " r3"}, dp_if.r3_debug, model[3]);
    check({tag, " hex"}, dp_if.hex_display_data, model[dp_if.display_reg_select]);
  endtask

  // Reference: operand values taken before the edge, result by plain arithmetic.
  task automatic do_op(input string tag, input logic we, input logic [1:0] op,
                       input logic bsel, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [7:0] imm);
    int a, b, r;
    dp_if.reg_write_enable_ctrl     = we;
    dp_if.alu_op_select_ctrl        = op;
    dp_if.alu_operand_b_select_ctrl = bsel;
    dp_if.rx_addr_instr             = rx;
    dp_if.ry_addr_instr             = ry;
    dp_if.immediate_instr           = imm;
    a = int'(model[rx]);
    b = bsel ? int'(imm) : int'(model[ry]);
    case (op)
      2'd0:    r = b;
      2'd1:    r = (a + b) % 256;
      2'd2:    r = a ^ b;
      default: r = a;
    endcase
    @(posedge clk);
    #1;
    if (we && rst_n) model[rx] = r[7:0];
    check_all(tag);
  endtask

  task automatic load(input string tag, input logic [1:0] rx, input logic [7:0] imm);
    do_op(tag, 1'b1, 2'd0, 1'b1, rx, 2'd0, imm);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
  endtask

  task automatic sweep_display(input string tag);
    for (int s = 0; s < 4; s++) begin
      dp_if.display_reg_select = s[1:0];
      #1;
      check(tag, dp_if.hex_display_data, model[s]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_model();
    rst_n = 1'b0;
    dp_if.reg_write_enable_ctrl     = 1'b1;
    dp_if.alu_op_select_ctrl        = 2'd0;
    dp_if.alu_operand_b_select_ctrl = 1'b1;
    dp_if.rx_addr_instr             = 2'd1;
    dp_if.ry_addr_instr             = 2'd0;
    dp_if.immediate_instr           = 8'h77;
    dp_if.display_reg_select        = 2'd1;

    // Write attempted while in reset must be suppressed.
    @(posedge clk);
    #1;
    check_all("reset");
    #2 rst_n = 1'b1;

    // Program sequence
    load("ld r0", 2'd0, 8'h05);
    load("ld r1", 2'd1, 8'h0A);
    do_op("add r0r1", 1'b1, 2'd1, 1'b0, 2'd0, 2'd1, 8'h00);
    check("add r0 abs", dp_if.r0_debug, 8'h0F);
    do_op("mov r2r0", 1'b1, 2'd0, 1'b0, 2'd2, 2'd0, 8'h00);
    load("ld r3", 2'd3, 8'hAA);
    do_op("xor r2r3", 1'b1, 2'd2, 1'b0, 2'd2, 2'd3, 8'h00);
    check("xor r2 abs", dp_if.r2_debug, 8'hA5);

    sweep_display("disp sweep");
    check("disp r2 abs", model[2], 8'hA5);

    // Write disable for 3 edges
    for (int i = 0; i < 3; i++)
      do_op("we0", 1'b0, 2'd0, 1'b1, 2'd3, 2'd0, 8'h55);
    check("we0 r3 abs", dp_if.r3_debug, 8'hAA);

    // PASS_A leaves Rx unchanged
    do_op("pass_a", 1'b1, 2'd3, 1'b1, 2'd2, 2'd0, 8'h12);

    // Overflow
    load("ld r0 ff", 2'd0, 8'hFF);
    load("ld r1 02", 2'd1, 8'h02);
    do_op("add ovf", 1'b1, 2'd1, 1'b0, 2'd0, 2'd1, 8'h00);
    check("ovf r0 abs", dp_if.r0_debug, 8'h01);
    check("ovf r1 abs", dp_if.r1_debug, 8'h02);

    // Self-operand
    load("ld r1 03", 2'd1, 8'h03);
    do_op("add r1r1", 1'b1, 2'd1, 1'b0, 2'd1, 2'd1, 8'h00);
    check("dbl r1 abs", dp_if.r1_debug, 8'h06);
    do_op("xor r1r1", 1'b1, 2'd2, 1'b0, 2'd1, 2'd1, 8'h00);
    check("xor self abs", dp_if.r1_debug, 8'h00);

    // Async reset between edges
    load("ld r2 3c", 2'd2, 8'h3C);
    rst_n = 1'b0;
    #1;
    clear_model();
    check_all("async rst");
    #1 rst_n = 1'b1;
    load("ld r1 07", 2'd1, 8'h07);
    check("post rst r1", dp_if.r1_debug, 8'h07);

    // Randomized ops with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      dp_if.display_reg_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("rand rst");
        #1 rst_n = 1'b1;
      end
      do_op("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    sweep_display("final sweep");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and there are 4 registers.
REQ-002 clk  input  1  clock; all register writes occur on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 reg_write_enable_ctrl  input  1  when 1, ALU result is written to register Rx at the next rising clk.
REQ-005 alu_op_select_ctrl  input  2  ALU operation select: 00 PASS_B, 01 ADD, 10 XOR, 11 PASS_A.
REQ-006 alu_operand_b_select_ctrl  input  1  operand B source: 0 = register Ry, 1 = immediate_instr.
REQ-007 rx_addr_instr  input  2  destination register index, and source of operand A.
REQ-008 ry_addr_instr  input  2  operand B register index.
REQ-009 immediate_instr  input  8  immediate operand.
REQ-010 display_reg_select  input  2  register index routed to hex_display_data.
REQ-011 hex_display_data  output  8  contents of register[display_reg_select].
REQ-012 r0_debug, r1_debug, r2_debug, r3_debug  output  8 each  current contents of R0..R3.

Function
REQ-013 The register file SHALL hold R0..R3, each 8 bits.
REQ-014 Operand A SHALL be R[rx_addr_instr]; both register reads SHALL be combinational.
REQ-015 Operand B SHALL be R[ry_addr_instr] when alu_operand_b_select_ctrl=0, else immediate_instr.
REQ-016 PASS_B result SHALL be operand B (used for LOAD with select=1 and MOV with select=0).
REQ-017 ADD result SHALL be (A+B) mod 256; the carry is discarded and no flags are produced.
REQ-018 XOR result SHALL be A XOR B, bitwise.
REQ-019 PASS_A result SHALL be A, so a write leaves Rx unchanged.
REQ-020 The ALU SHALL be purely combinational.
REQ-021 On a rising clk with reg_write_enable_ctrl=1 and rst_n=1, R[rx_addr_instr] SHALL take the ALU result; other registers SHALL hold.
REQ-022 With reg_write_enable_ctrl=0, no register SHALL change.
REQ-023 Writeback SHALL be read-before-write: operands use pre-edge values, and the new value is visible on reads and outputs after the edge.
REQ-024 Rx==Ry SHALL be legal, using the same pre-edge value for both operands (e.g. ADD R1,R1 doubles R1).
REQ-025 hex_display_data and the rN_debug outputs SHALL be combinational from the register contents, with no added latency.
REQ-026 A change of display_reg_select SHALL update hex_display_data within the same cycle, independent of clk.

Reset
REQ-027 While rst_n=0, R0..R3 SHALL be 8'h00 immediately, regardless of clk, so all rN_debug outputs and hex_display_data read 8'h00.
REQ-028 While rst_n=0, writes SHALL be suppressed; normal operation SHALL resume at the first rising clk after rst_n deasserts.
REQ-029 Reset asserted mid-sequence SHALL discard all register contents; no write SHALL complete on an edge coincident with rst_n=0.

Verification
REQ-030 Program sequence -> after each edge:
- LOAD R0,5 (we=1, op=00, bsel=1, rx=0, imm=05) -> R0=05
- LOAD R1,10 -> R1=0A
- ADD R0,R1 (op=01, bsel=0, rx=0, ry=1) -> R0=0F
- MOV R2,R0 (op=00, bsel=0, rx=2, ry=0) -> R2=0F
- LOAD R3,AA -> R3=AA
- XOR R2,R3 (op=10, bsel=0, rx=2, ry=3) -> R2=A5
REQ-031 Overflow: R0=FF, R1=02, then ADD R0,R1 -> R0=01, R1 unchanged at 02.
REQ-032 Write disable: we=0 with op=00, bsel=1, imm=55, rx=3 for 3 edges -> R3 keeps its prior value.
REQ-033 Display mux: after REQ-030, sweep display_reg_select 0..3 -> hex_display_data = 0F, 0A, A5, AA, each equal to the matching rN_debug.
REQ-034 Async reset: with registers nonzero, pulse rst_n low between clk edges -> all outputs 00 before the next edge; after release, LOAD R1,7 -> R1=07 with others 00.
REQ-035 Self-operand: R1=03, then ADD R1,R1 -> R1=06; then XOR R1,R1 -> R1=00.
